// File: rtl/video_timing_pkg.sv
// video_timing_pkg
//   Shared constants and helpers for the raster timing generator.
//   - DEF_*        : 640x480@60 timing and the default content window
//   - pulse_t      : bundle of the per-line event pulses
//   - pix_rep_legal: accepted pixel/line repetition factors
//   - axis_total   : clocks (or lines) in one full axis period
package video_timing_pkg;

  localparam int DEF_H_ACTIVE    = 640;
  localparam int DEF_H_FP        = 16;
  localparam int DEF_H_SYNC      = 96;
  localparam int DEF_H_BP        = 48;
  localparam int DEF_V_ACTIVE    = 480;
  localparam int DEF_V_FP        = 10;
  localparam int DEF_V_SYNC      = 2;
  localparam int DEF_V_BP        = 33;
  localparam int DEF_PIX_REP     = 2;
  localparam int DEF_WIN_X       = 32;
  localparam int DEF_WIN_Y       = 24;
  localparam int DEF_WIN_W       = 256;
  localparam int DEF_WIN_H       = 192;
  localparam int DEF_RENDER_LEAD = 1;
  localparam int DEF_PW          = 9;

  typedef struct packed {
    logic render;
    logic irq;
    logic frame;
  } pulse_t;

  function automatic bit pix_rep_legal(input int rep);
    return (rep == 1) || (rep == 2);
  endfunction

  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/video_axis_counter.sv
// video_axis_counter
//   One raster axis: a wrapping counter ordered active, front porch,
//   sync, back porch, plus the decoded sync and blank levels.
//   Ports:
//     clk, reset_n : clock, asynchronous active-low reset
//     advance      : count enable (1 for the H axis, hlast for the V axis)
//     count        : current position, 0..TOTAL-1
//     last         : count == TOTAL-1 (combinational)
//     sync         : POL while count is inside the sync interval, else !POL
//     blank        : count is past the active interval
module video_axis_counter
  import video_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter bit POL    = 1'b0,
  parameter int CW     = $clog2(ACTIVE + FP + SYNC + BP + 1)
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          advance,
  output logic [CW-1:0] count,
  output logic          last,
  output logic          sync,
  output logic          blank
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  localparam logic [CW-1:0] LAST_C  = CW'(TOTAL - 1);
  localparam logic [CW-1:0] SYNC_LO = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_HI = CW'(ACTIVE + FP + SYNC);
  localparam logic [CW-1:0] ACT_C   = CW'(ACTIVE);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (advance) begin
      count <= last ? '0 : count + 1'b1;
    end
  end

  assign last  = (count == LAST_C);
  assign sync  = ((count >= SYNC_LO) && (count < SYNC_HI)) ? POL : ~POL;
  assign blank = (count >= ACT_C);

endmodule

// File: rtl/video_timing_gen.sv
// video_timing_gen
//   Parametrised raster timing generator with 1x/2x repetition, content
//   window decode, render look-ahead, line interrupt and frame pulse.
//   Ports:
//     clk, reset_n     : pixel clock, asynchronous active-low reset
//     left_col_blank   : turns the first 8 logical columns of the window
//                        into border
//     irq_en, irq_line : line interrupt enable and window line
//     hpos, vpos       : window-relative logical coordinates, 0 outside
//     hsync, vsync     : sync outputs at the configured polarity
//     blank            : outside the visible area
//     border           : visible but outside the active window
//     render_start     : one-clock pulse, render_line is the line to draw
//     render_line      : held between render_start pulses
//     line_irq_pulse   : one-clock pulse after the selected window line
//     frame_start      : one-clock pulse after the last line of a frame
//   hpos/vpos/sync/blank/border are combinational from the counters;
//   the pulses are registered one clock after hlast.
module video_timing_gen
  import video_timing_pkg::*;
#(
  parameter int H_ACTIVE    = DEF_H_ACTIVE,
  parameter int H_FP        = DEF_H_FP,
  parameter int H_SYNC      = DEF_H_SYNC,
  parameter int H_BP        = DEF_H_BP,
  parameter int V_ACTIVE    = DEF_V_ACTIVE,
  parameter int V_FP        = DEF_V_FP,
  parameter int V_SYNC      = DEF_V_SYNC,
  parameter int V_BP        = DEF_V_BP,
  parameter bit HSYNC_POL   = 1'b0,
  parameter bit VSYNC_POL   = 1'b0,
  parameter int PIX_REP     = DEF_PIX_REP,
  parameter int WIN_X       = DEF_WIN_X,
  parameter int WIN_Y       = DEF_WIN_Y,
  parameter int WIN_W       = DEF_WIN_W,
  parameter int WIN_H       = DEF_WIN_H,
  parameter int RENDER_LEAD = DEF_RENDER_LEAD,
  parameter int PW          = DEF_PW
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          left_col_blank,
  input  logic          irq_en,
  input  logic [PW-1:0] irq_line,
  output logic [PW-1:0] hpos,
  output logic [PW-1:0] vpos,
  output logic          hsync,
  output logic          vsync,
  output logic          blank,
  output logic          border,
  output logic          render_start,
  output logic [PW-1:0] render_line,
  output logic          line_irq_pulse,
  output logic          frame_start
);

  localparam int HTOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int VTOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam int HW     = $clog2(HTOTAL + 1);
  localparam int VW     = $clog2(VTOTAL + 1);
  // Logical frame height; an odd VTOTAL (525 by default) rounds down.
  localparam int VLOG   = VTOTAL / PIX_REP;
  localparam int SH     = PIX_REP - 1;
  // Wide enough for ynext + RENDER_LEAD + VLOG - WIN_Y < 3*VLOG.
  localparam int LW     = VW + 2;

  localparam logic [HW-1:0] X0 = HW'(WIN_X);
  localparam logic [HW-1:0] X8 = HW'(WIN_X + 8);
  localparam logic [HW-1:0] XE = HW'(WIN_X + WIN_W);
  localparam logic [VW-1:0] Y0 = VW'(WIN_Y);
  localparam logic [VW-1:0] YE = VW'(WIN_Y + WIN_H);

  localparam logic [LW-1:0] LOFS   = LW'(RENDER_LEAD + VLOG - WIN_Y);
  localparam logic [LW-1:0] VLOG_L = LW'(VLOG);
  localparam logic [LW-1:0] WINH_L = LW'(WIN_H);
  localparam logic [PW:0]   WINH_P = (PW + 1)'(WIN_H);

  // Parameter legality. The divisibility rule is applied to the visible
  // height so that the odd 525-line default total stays legal.
  if (!pix_rep_legal(PIX_REP)) begin : g_bad_rep
    $error("video_timing_gen: PIX_REP must be 1 or 2");
  end
  if ((H_ACTIVE % PIX_REP) != 0 || (V_ACTIVE % PIX_REP) != 0) begin : g_bad_div
    $error("video_timing_gen: active size not divisible by PIX_REP");
  end
  if (WIN_X + WIN_W > H_ACTIVE / PIX_REP) begin : g_bad_winx
    $error("video_timing_gen: window exceeds active width");
  end
  if (WIN_Y + WIN_H > V_ACTIVE / PIX_REP) begin : g_bad_winy
    $error("video_timing_gen: window exceeds active height");
  end
  if (RENDER_LEAD >= VLOG || WIN_H > (1 << PW)) begin : g_bad_lead
    $error("video_timing_gen: RENDER_LEAD or WIN_H out of range");
  end

  logic [HW-1:0] hcnt;
  logic [VW-1:0] vcnt;
  logic          hlast, vlast, h_blank, v_blank;

  video_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP),
    .POL(HSYNC_POL), .CW(HW)
  ) u_hcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (1'b1),
    .count   (hcnt),
    .last    (hlast),
    .sync    (hsync),
    .blank   (h_blank)
  );

  video_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP),
    .POL(VSYNC_POL), .CW(VW)
  ) u_vcnt (
    .clk     (clk),
    .reset_n (reset_n),
    .advance (hlast),
    .count   (vcnt),
    .last    (vlast),
    .sync    (vsync),
    .blank   (v_blank)
  );

  // Window decode (zero latency from the counters)
  logic [HW-1:0] x, xstart;
  logic [VW-1:0] y, wline;
  logic          in_x, in_y, active;

  assign blank  = h_blank | v_blank;
  assign x      = hcnt >> SH;
  assign y      = vcnt >> SH;
  assign xstart = left_col_blank ? X8 : X0;
  assign in_x   = (x >= xstart) && (x < XE);
  assign in_y   = (y >= Y0) && (y < YE);
  assign active = !blank && in_x && in_y;
  assign border = !blank && !active;
  assign hpos   = active ? PW'(x - X0) : '0;
  assign vpos   = active ? PW'(y - Y0) : '0;
  assign wline  = y - Y0;

  // Render look-ahead: window line of the logical line RENDER_LEAD ahead
  // of the one about to start, modulo the logical frame height.
  logic [VW-1:0] vnext, ynext;
  logic [LW-1:0] lsum, lmod1, lmod2;
  logic          next_phase0, last_phase;

  assign vnext       = vlast ? '0 : vcnt + 1'b1;
  assign ynext       = vnext >> SH;
  assign next_phase0 = (PIX_REP == 1) || !vnext[0];
  assign last_phase  = (PIX_REP == 1) || vcnt[0];
  assign lsum        = LW'(ynext) + LOFS;
  assign lmod1       = (lsum  >= VLOG_L) ? lsum  - VLOG_L : lsum;
  assign lmod2       = (lmod1 >= VLOG_L) ? lmod1 - VLOG_L : lmod1;

  pulse_t pulse_d;

  assign pulse_d = '{
    render: hlast && next_phase0 && (lmod2 < WINH_L),
    irq:    hlast && irq_en && last_phase && in_y &&
            ({1'b0, irq_line} < WINH_P) && (PW'(wline) == irq_line),
    frame:  hlast && vlast
  };

  // Registered pulse stage
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      render_start   <= 1'b0;
      line_irq_pulse <= 1'b0;
      frame_start    <= 1'b0;
      render_line    <= '0;
    end else begin
      render_start   <= pulse_d.render;
      line_irq_pulse <= pulse_d.irq;
      frame_start    <= pulse_d.frame;
      if (pulse_d.render) begin
        render_line <= PW'(lmod2);
      end
    end
  end

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen using a reduced raster so several frames fit
// in a short run: 80 clocks x 56 lines, 2x repetition, window at logical
// (4,1) size 20x16, render lead 2 (WIN_Y < lead exercises the wrap).
module tb_video_timing_gen;

  localparam int H_ACTIVE = 64, H_FP = 4, H_SYNC = 8, H_BP = 4;
  localparam int V_ACTIVE = 48, V_FP = 2, V_SYNC = 2, V_BP = 4;
  localparam bit HPOL = 1'b0, VPOL = 1'b0;
  localparam int PR = 2;
  localparam int WIN_X = 4, WIN_Y = 1, WIN_W = 20, WIN_H = 16;
  localparam int LEAD = 2, PW = 9;
  localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int VLOG = VT / PR;
  localparam int FRAME = HT * VT;

  logic          clk, reset_n, left_col_blank, irq_en;
  logic [PW-1:0] irq_line, hpos, vpos, render_line;
  logic          hsync, vsync, blank, border;
  logic          render_start, line_irq_pulse, frame_start;

  video_timing_gen #(
    .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
    .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .PIX_REP(PR),
    .WIN_X(WIN_X), .WIN_Y(WIN_Y), .WIN_W(WIN_W), .WIN_H(WIN_H),
    .RENDER_LEAD(LEAD), .PW(PW)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .left_col_blank (left_col_blank),
    .irq_en         (irq_en),
    .irq_line       (irq_line),
    .hpos           (hpos),
    .vpos           (vpos),
    .hsync          (hsync),
    .vsync          (vsync),
    .blank          (blank),
    .border         (border),
    .render_start   (render_start),
    .render_line    (render_line),
    .line_irq_pulse (line_irq_pulse),
    .frame_start    (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0, n_fail = 0;
  int n_rs = 0, n_irq = 0;
  int cyc;
  int exp_rl;
  logic          edge_irq_en;
  logic [PW-1:0] edge_irq_line;

  task automatic chk(input string name, input int at, input int act, input int want);
    n_cmp++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s @cyc %0d: got %0d, want %0d", name, at, act, want);
    end
  endtask

  typedef struct packed {
    bit hs; bit vs; bit bl; bit bd;
    int hp; int vp;
    bit rs; int rl; bit irq; bit fs;
  } exp_t;

  // Expected outputs at position p (clocks since reset release).
  function automatic exp_t model(input int p, input bit lcb, input bit ien, input int iline);
    exp_t e;
    int h, v, x, y, q, hq, vq, vn, l;
    bit act;
    h = p % HT; v = (p / HT) % VT; x = h / PR; y = v / PR;
    e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? HPOL : !HPOL;
    e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? VPOL : !VPOL;
    e.bl = (h >= H_ACTIVE) || (v >= V_ACTIVE);
    act = !e.bl && x >= WIN_X + (lcb ? 8 : 0) && x < WIN_X + WIN_W &&
          y >= WIN_Y && y < WIN_Y + WIN_H;
    e.bd = !e.bl && !act;
    e.hp = act ? x - WIN_X : 0;
    e.vp = act ? y - WIN_Y : 0;
    e.rs = 1'b0; e.rl = 0; e.irq = 1'b0; e.fs = 1'b0;
    if (p >= 1) begin
      q = p - 1; hq = q % HT; vq = (q / HT) % VT;
      if (hq == HT - 1) begin
        e.fs = (vq == VT - 1);
        vn = (vq + 1) % VT;
        if (vn % PR == 0) begin
          l = ((vn / PR + LEAD - WIN_Y) % VLOG + VLOG) % VLOG;
          if (l < WIN_H) begin
            e.rs = 1'b1;
            e.rl = l;
          end
        end
        if (ien && (vq % PR == PR - 1) && (vq / PR >= WIN_Y) &&
            (vq / PR - WIN_Y == iline) && (iline < WIN_H))
          e.irq = 1'b1;
      end
    end
    return e;
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cyc           <= 0;
      edge_irq_en   <= 1'b0;
      edge_irq_line <= '0;
    end else begin
      cyc           <= cyc + 1;
      edge_irq_en   <= irq_en;
      edge_irq_line <= irq_line;
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset_n) begin
      exp_rl = 0;
    end else begin
      e = model(cyc, left_col_blank, edge_irq_en, int'(edge_irq_line));
      if (e.rs) exp_rl = e.rl;
      chk("hsync",          cyc, int'(hsync),          int'(e.hs));
      chk("vsync",          cyc, int'(vsync),          int'(e.vs));
      chk("blank",          cyc, int'(blank),          int'(e.bl));
      chk("border",         cyc, int'(border),         int'(e.bd));
      chk("hpos",           cyc, int'(hpos),           e.hp);
      chk("vpos",           cyc, int'(vpos),           e.vp);
      chk("render_start",   cyc, int'(render_start),   int'(e.rs));
      chk("render_line",    cyc, int'(render_line),    exp_rl);
      chk("line_irq_pulse", cyc, int'(line_irq_pulse), int'(e.irq));
      chk("frame_start",    cyc, int'(frame_start),    int'(e.fs));
      if (render_start)   n_rs++;
      if (line_irq_pulse) n_irq++;
    end
  end

  task automatic goto(input int target);
    int guard = 0;
    while (cyc < target) begin
      @(negedge clk);
      guard++;
      if (guard > 3 * FRAME) begin
        n_fail++;
        $display("FAIL goto_timeout @cyc %0d: got %0d, want %0d", cyc, cyc, target);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $fatal(1, "cycle budget exhausted");
      end
    end
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_hsync"},  0, int'(hsync), 1);
    chk({tag, "_vsync"},  0, int'(vsync), 1);
    chk({tag, "_blank"},  0, int'(blank), 0);
    chk({tag, "_border"}, 0, int'(border), 1);
    chk({tag, "_hpos"},   0, int'(hpos), 0);
    chk({tag, "_vpos"},   0, int'(vpos), 0);
    chk({tag, "_rs"},     0, int'(render_start), 0);
    chk({tag, "_rl"},     0, int'(render_line), 0);
    chk({tag, "_irq"},    0, int'(line_irq_pulse), 0);
    chk({tag, "_fs"},     0, int'(frame_start), 0);
  endtask

  initial begin
    reset_n = 1'b0; left_col_blank = 1'b0; irq_en = 1'b1; irq_line = 9'd5;
    repeat (2) @(negedge clk);
    check_reset_state("rst0");
    #1 reset_n = 1'b1;

    // Frame 1: default window, irq on window line 5
    goto(67);   chk("hs_67",  cyc, int'(hsync), 1);
    goto(68);   chk("hs_68",  cyc, int'(hsync), 0);
    goto(75);   chk("hs_75",  cyc, int'(hsync), 0);
    goto(76);   chk("hs_76",  cyc, int'(hsync), 1);
    goto(100);  chk("bd_top", cyc, int'(border), 1);
    goto(159);  chk("rs_159", cyc, int'(render_start), 0);
    goto(160);  chk("rs_160", cyc, int'(render_start), 1);
                chk("rl_160", cyc, int'(render_line), 2);
    goto(327);  chk("bd_327", cyc, int'(border), 1);
    goto(328);  chk("hp_328", cyc, int'(hpos), 0);
                chk("bd_328", cyc, int'(border), 0);
                chk("vp_328", cyc, int'(vpos), 1);
    goto(329);  chk("hp_329", cyc, int'(hpos), 0);
    goto(330);  chk("hp_330", cyc, int'(hpos), 1);
    goto(368);  chk("bd_368", cyc, int'(border), 1);
    goto(384);  chk("bl_384", cyc, int'(blank), 1);
    goto(1119); chk("irq_1119", cyc, int'(line_irq_pulse), 0);
    goto(1120); chk("irq_1120", cyc, int'(line_irq_pulse), 1);
                chk("rs_1120",  cyc, int'(render_start), 1);
                chk("rl_1120",  cyc, int'(render_line), 8);
    goto(3999); chk("vs_3999", cyc, int'(vsync), 1);
    goto(4000); chk("vs_4000", cyc, int'(vsync), 0);
    goto(4159); chk("vs_4159", cyc, int'(vsync), 0);
    goto(4160); chk("vs_4160", cyc, int'(vsync), 1);
    goto(4319); chk("rs_4319", cyc, int'(render_start), 0);
    goto(4320); chk("rs_wrap", cyc, int'(render_start), 1);
                chk("rl_wrap", cyc, int'(render_line), 0);
    goto(4479); chk("fs_4479", cyc, int'(frame_start), 0);
                chk("nrs_f1",  cyc, n_rs, 15);
    goto(4480); chk("fs_4480", cyc, int'(frame_start), 1);
                chk("rs_4480", cyc, int'(render_start), 1);
                chk("rl_4480", cyc, int'(render_line), 1);

    // Frame 2: left column blanked, irq moved to the last window line
    goto(4481); #1 left_col_blank = 1'b1; irq_line = 9'd15;
    goto(4808); chk("lcb_bd_4808", cyc, int'(border), 1);
                chk("lcb_hp_4808", cyc, int'(hpos), 0);
    goto(4823); chk("lcb_bd_4823", cyc, int'(border), 1);
    goto(4824); chk("lcb_hp_4824", cyc, int'(hpos), 8);
                chk("lcb_bd_4824", cyc, int'(border), 0);
    goto(7199); chk("irq_7199", cyc, int'(line_irq_pulse), 0);
    goto(7200); chk("irq_7200", cyc, int'(line_irq_pulse), 1);
    goto(8959); chk("fs_8959", cyc, int'(frame_start), 0);
                chk("nrs_f2",  cyc, n_rs, 31);
                chk("nirq_f2", cyc, n_irq, 2);
    goto(8960); chk("fs_8960", cyc, int'(frame_start), 1);

    // Frame 3: irq_line beyond the window never fires; reset at line 30
    goto(8961); #1 left_col_blank = 1'b0; irq_line = 9'd16;
    goto(8960 + 30 * HT);
    chk("nirq_f3", cyc, n_irq, 2);
    #1 reset_n = 1'b0;
    #1 check_reset_state("rst1");
    irq_en = 1'b0; irq_line = 9'd5;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_state("rst2");
    #1 reset_n = 1'b1;

    goto(4479); chk("fs_post_4479", cyc, int'(frame_start), 0);
    goto(4480); chk("fs_post_4480", cyc, int'(frame_start), 1);
                chk("nirq_post",    cyc, n_irq, 2);
    goto(4490);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
